// File: rtl/fetch_pkg.sv
// Shared types, widths and address helpers for the instruction fetch unit.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // Wraps naturally from the top word back to zero.
    function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: core redirect, instruction memory port and instruction hand-off.
interface inst_fetch_if;
    import fetch_pkg::*;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// In-order instruction buffer with flush; head is read directly from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    fetch_entry_t     mem_r [SLOTS];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests so a full buffer only accepts a push alongside a pop.
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (do_push_s && !do_pop_s)      count_r <= count_r + CNT_ONE;
            else if (!do_push_s && do_pop_s) count_r <= count_r - CNT_ONE;
            else                             count_r <= count_r;
        end
    end

    // Entry storage, cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) mem_r[i] <= '0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: at most one outstanding memory read feeding an in-order buffer.
// Build macro FETCH_BUF_EN selects a BUF_DEPTH-entry buffer; otherwise a single holding slot.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);

`ifdef FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif
    localparam int DEPTH = BUF_EN ? BUF_DEPTH : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_state_t      state_r;
    fetch_state_t      state_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] drain_addr_r;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W-1:0]  count_after_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              issue_ok_s;
    logic              active_s;
    logic              req_s;
    logic              ack_s;
    logic              push_s;
    logic              full_next_s;
    logic [ADDR_W-1:0] addr_s;
    fetch_entry_t      head_s;
    fetch_entry_t      wdata_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Request qualification and buffer control for the current cycle.
    always_comb begin
        pop_s      = !empty_s && bus.inst_ready;
        issue_ok_s = !full_s || pop_s;
        case (state_r)
            IDLE:    active_s = issue_ok_s && !bus.redirect_valid;
            REQ:     active_s = 1'b1;
            DRAIN:   active_s = 1'b0;
            default: active_s = 1'b0;
        endcase
        req_s   = !rst && (active_s || (state_r == DRAIN));
        ack_s   = req_s && bus.imem_ack;
        push_s  = active_s && ack_s && !bus.redirect_valid;
        addr_s  = (state_r == DRAIN) ? drain_addr_r : fetch_pc_r;
        wdata_s = '{inst: bus.imem_rdata, pc: addr_s};
        if (push_s && !pop_s)      count_after_s = count_s + CNT_ONE;
        else if (!push_s && pop_s) count_after_s = count_s - CNT_ONE;
        else                       count_after_s = count_s;
        full_next_s = (count_after_s == DEPTH_C);
    end

    // Next-state logic; a same-cycle ack on redirect is simply dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (active_s) state_s = (ack_s && full_next_s) ? IDLE : REQ;
                else          state_s = IDLE;
            end
            REQ: begin
                if (bus.redirect_valid) state_s = ack_s ? IDLE : DRAIN;
                else if (ack_s)         state_s = full_next_s ? IDLE : REQ;
                else                    state_s = REQ;
            end
            DRAIN: begin
                if (ack_s) state_s = REQ;
                else       state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Fetch pointer and the address held by a request being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r   <= RESET_PC;
            drain_addr_r <= RESET_PC;
        end else begin
            if (bus.redirect_valid) fetch_pc_r <= align_word(bus.redirect_pc);
            else if (push_s)        fetch_pc_r <= next_word(fetch_pc_r);
            if ((state_r == REQ) && bus.redirect_valid && !ack_s) drain_addr_r <= fetch_pc_r;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (bus.redirect_valid),
        .wdata (wdata_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign bus.imem_req   = req_s;
    assign bus.imem_addr  = addr_s;
    assign bus.inst_valid = !empty_s;
    assign bus.inst_data  = head_s.inst;
    assign bus.inst_pc    = head_s.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_inst_fetch;

`ifdef FETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    inst_fetch_if bus();
    inst_fetch_if bus2();

    inst_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    assign bus.imem_rdata  = word_of(bus.imem_addr);
    assign bus2.imem_rdata = word_of(bus2.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
        bus.imem_ack       = ack;
        bus.inst_ready     = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
    endtask

    vec_t        tbl [11];
    logic [31:0] wrap_exp [4];

    // Reference model state.
    ent_t        q[$];
    logic [31:0] npc;
    int          out_kind;  // 0 none, 1 live request, 2 request to discard
    logic [31:0] out_addr;
    logic        ack_v, rdy_v, redir_v, e_req, e_valid, pop_v, ackd;
    logic [31:0] rpc_v, e_addr;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 32'h10,  1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        bus2.imem_ack       = 1'b1;
        bus2.inst_ready     = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req",    {31'd0, bus.imem_req},   32'd0);
        chk("rst_addr",   bus.imem_addr,           32'h0);
        chk("rst_valid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_data",   bus.inst_data,           32'h0);
        chk("rst_pc",     bus.inst_pc,             32'h0);
        chk("rst2_addr",  bus2.imem_addr,          32'hFFFF_FFF8);
        chk("rst2_req",   {31'd0, bus2.imem_req},  32'd0);

        // Directed table: streaming, redirect into drain, realignment, resume.
        @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            #1;
            chk($sformatf("tbl%0d_req", i), {31'd0, bus.imem_req}, {31'd0, tbl[i].ereq});
            if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, bus.inst_valid}, {31'd0, tbl[i].evalid});
            if (tbl[i].evalid) begin
                chk($sformatf("tbl%0d_pc", i), bus.inst_pc, tbl[i].epc);
                chk($sformatf("tbl%0d_data", i), bus.inst_data, word_of(tbl[i].epc));
            end
            if (i >= 1 && i <= 4) begin
                chk($sformatf("wrap%0d_pc", i), bus2.inst_pc, wrap_exp[i-1]);
                chk($sformatf("wrap%0d_data", i), bus2.inst_data, word_of(wrap_exp[i-1]));
            end
            @(negedge clk);
        end

        // Stall: exactly DEPTH requests are accepted, then the head holds.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            chk("stall_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("stall_addr", bus.imem_addr, 32'h104 + 32'(4 * k));
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            chk("hold_req",   {31'd0, bus.imem_req},   32'd0);
            chk("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("hold_pc",    bus.inst_pc,             32'h104);
            chk("hold_data",  bus.inst_data,           word_of(32'h104));
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("resume_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("resume_addr", bus.imem_addr, 32'h104 + 32'(4 * DEPTH));
        chk("resume_pc",   bus.inst_pc, 32'h104);

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("pend_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("pend_addr", bus.imem_addr, 32'h104 + 32'(4 * DEPTH));
        #2;
        rst = 1'b1;
        #1;
        chk("abort_req",   {31'd0, bus.imem_req},   32'd0);
        chk("abort_addr",  bus.imem_addr,           32'h0);
        chk("abort_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("abort_data",  bus.inst_data,           32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the reference model.
        q.delete();
        npc      = 32'h0;
        out_kind = 0;
        out_addr = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            ack_v   = ($urandom_range(0, 3) != 0);
            rdy_v   = ($urandom_range(0, 2) != 0);
            redir_v = ($urandom_range(0, 9) == 0);
            rpc_v   = $urandom();
            drive(ack_v, rdy_v, redir_v, rpc_v);
            e_valid = (q.size() > 0);
            pop_v   = e_valid && rdy_v;
            if (out_kind != 0) begin
                e_req  = 1'b1;
                e_addr = out_addr;
            end else if (!redir_v && ((q.size() < DEPTH) || pop_v)) begin
                e_req  = 1'b1;
                e_addr = npc;
            end else begin
                e_req  = 1'b0;
                e_addr = 32'h0;
            end
            #1;
            chk("rnd_req", {31'd0, bus.imem_req}, {31'd0, e_req});
            if (e_req) chk("rnd_addr", bus.imem_addr, e_addr);
            chk("rnd_valid", {31'd0, bus.inst_valid}, {31'd0, e_valid});
            if (e_valid) begin
                chk("rnd_pc",   bus.inst_pc,   q[0].pc);
                chk("rnd_data", bus.inst_data, q[0].inst);
            end
            @(posedge clk);
            ackd = e_req && ack_v;
            if (redir_v) begin
                q.delete();
                npc = {rpc_v[31:2], 2'b00};
                if (out_kind == 2)      out_kind = ackd ? 1 : 2;
                else if (out_kind == 1) out_kind = ackd ? 0 : 2;
                else                    out_kind = 0;
                if (out_kind == 1) out_addr = npc;
            end else begin
                if (pop_v) void'(q.pop_front());
                if (ackd && out_kind == 2) begin
                    out_kind = 1;
                    out_addr = npc;
                end else if (ackd) begin
                    q.push_back('{inst: word_of(e_addr), pc: e_addr});
                    npc      = e_addr + 32'd4;
                    out_kind = (q.size() < DEPTH) ? 1 : 0;
                    out_addr = npc;
                end else if (e_req && out_kind == 0) begin
                    out_kind = 1;
                    out_addr = e_addr;
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
